imem_loader: RTL and testbench

- Run-time writer for the instruction "text" memory.
- Accepts a byte stream from a host link (UART/bench) with a valid/ready handshake.
- Assembles bytes MSB-first into n-bit words and issues one-cycle write strobes at sequential word addresses starting at 0.
- Sits between the host link and the write port of the instruction RAM; `busy` holds the CPU in reset while a load is in progress.

---
 rtl/imem_loader_if.sv | 23 ++
 rtl/imem_loader.sv | 107 ++++++++++
 tb/tb_imem_loader.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-RAM write port of the text-memory loader.
// The loader takes the slave side; the host/RAM side takes the master side.
interface imem_loader_if #(
  parameter int n = 32,
  parameter int r = 6
);
  logic         byte_valid;
  logic [7:0]   byte_data;
  logic         byte_ready;
  logic         we;
  logic [r-1:0] waddr;
  logic [n-1:0] wdata;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, we, waddr, wdata
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, we, waddr, wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Run-time instruction-memory loader: packs a host byte stream MSB-first into
// n-bit words and writes them to sequential word addresses starting at 0.
module imem_loader #(
  parameter int n = 32,
  parameter int r = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [r:0]   load_len,
  imem_loader_if.slave bus,
  output logic         busy,
  output logic         done
);
  localparam int nb = n / 8;
  localparam int bw = (nb > 1) ? $clog2(nb) : 1;
  localparam logic [bw-1:0] last_byte = bw'(nb - 1);
  localparam logic [bw-1:0] byte_one  = 1;
  localparam logic [r-1:0]  word_one  = 1;
  localparam logic [r:0]    len_one   = 1;
  localparam logic [r:0]    depth     = {1'b1, {r{1'b0}}};

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t         state;
  state_t         state_next;
  logic [r:0]     len;
  logic [r-1:0]   word_idx;
  logic [bw-1:0]  byte_idx;
  logic [n-1:0]   shift;
  logic           byte_ready;
  logic           we;
  logic           accept;
  logic           last_word;

  assign accept    = bus.byte_valid && byte_ready;
  assign last_word = ({1'b0, word_idx} == (len - len_one));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start) state_next = (load_len == '0) ? DONE : COLLECT;
      COLLECT: if (accept && (byte_idx == last_byte)) state_next = WRITE;
      WRITE:   state_next = last_word ? DONE : COLLECT;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Every output is a decode of the state register, so none follows an input
  // combinationally.
  always_comb begin
    byte_ready = 1'b0;
    we         = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    unique case (state)
      COLLECT: begin byte_ready = 1'b1; busy = 1'b1; end
      WRITE:   begin we = 1'b1; busy = 1'b1; end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Requested lengths above the memory depth are clamped so waddr never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      len      <= '0;
      word_idx <= '0;
      byte_idx <= '0;
      shift    <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            len      <= (load_len > depth) ? depth : load_len;
            word_idx <= '0;
            byte_idx <= '0;
          end
        end
        COLLECT: begin
          if (accept) begin
            shift    <= (shift << 8) | n'(bus.byte_data);
            byte_idx <= byte_idx + byte_one;
          end
        end
        WRITE: begin
          if (!last_word) begin
            word_idx <= word_idx + word_one;
            byte_idx <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.byte_ready = byte_ready;
  assign bus.we         = we;
  assign bus.waddr      = word_idx;
  assign bus.wdata      = shift;
endmodule

// File: tb/tb_imem_loader.sv
// Directed testbench for imem_loader: each task drives one scenario and checks
// the write log, done/busy timing and output values against hand-computed values.
module tb_imem_loader;
  localparam int n = 32;
  localparam int r = 6;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [r:0]   load_len;
  logic         busy;
  logic         done;

  imem_loader_if #(.n(n), .r(r)) bus();

  imem_loader #(.n(n), .r(r)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .load_len (load_len),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  logic [r-1:0] wr_addr[$];
  logic [n-1:0] wr_data[$];
  int           wr_cyc[$];
  int           done_cnt;
  int           done_cyc;
  bit           busy_seen;
  bit           ready_in_write;

  // Write/done monitor, sampled mid-cycle away from the active edge.
  always @(negedge clk) begin
    if (bus.we === 1'b1) begin
      wr_addr.push_back(bus.waddr);
      wr_data.push_back(bus.wdata);
      wr_cyc.push_back(cyc);
      if (bus.byte_ready === 1'b1) ready_in_write = 1'b1;
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (busy === 1'b1) busy_seen = 1'b1;
  end

  int checks = 0;
  int passes = 0;
  bit timeout_seen = 1'b0;
  int last_accept = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    done_cnt       = 0;
    done_cyc       = -1;
    busy_seen      = 1'b0;
    ready_in_write = 1'b0;
    timeout_seen   = 1'b0;
  endtask

  task automatic start_load(input logic [r:0] len);
    start    = 1'b1;
    load_len = len;
    tick();
    start    = 1'b0;
  endtask

  // Presents a byte and holds it until the loader takes it; valid stays high.
  task automatic send_byte(input logic [7:0] b);
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    for (int i = 0; i < 20 && bus.byte_ready !== 1'b1; i++) tick();
    if (bus.byte_ready !== 1'b1) timeout_seen = 1'b1;
    else begin
      tick();
      last_accept = cyc;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
    checks++; if (bus.byte_ready !== 1'b0) $display("[TB] FAIL reset_byte_ready: got %b expected 0", bus.byte_ready); else passes++;
    checks++; if (bus.we !== 1'b0) $display("[TB] FAIL reset_we: got %b expected 0", bus.we); else passes++;
    checks++; if (bus.waddr !== '0) $display("[TB] FAIL reset_waddr: got %h expected 0", bus.waddr); else passes++;
    checks++; if (bus.wdata !== '0) $display("[TB] FAIL reset_wdata: got %h expected 0", bus.wdata); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passes++;
  endtask

  task automatic test_two_words();
    clear_log();
    start_load(7'd2);
    send_word(32'h20080005);
    send_word(32'hAC080040);
    bus.byte_valid = 1'b0;
    idle(3);
    checks++; if (wr_addr.size() !== 2) $display("[TB] FAIL two_words_count: got %0d expected 2", wr_addr.size()); else passes++;
    if (wr_addr.size() == 2) begin
      checks++; if (wr_addr[0] !== 6'd0) $display("[TB] FAIL two_words_addr0: got %h expected 0", wr_addr[0]); else passes++;
      checks++; if (wr_data[0] !== 32'h20080005) $display("[TB] FAIL two_words_data0: got %h expected 20080005", wr_data[0]); else passes++;
      checks++; if (wr_addr[1] !== 6'd1) $display("[TB] FAIL two_words_addr1: got %h expected 1", wr_addr[1]); else passes++;
      checks++; if (wr_data[1] !== 32'hAC080040) $display("[TB] FAIL two_words_data1: got %h expected ac080040", wr_data[1]); else passes++;
      checks++; if (wr_cyc[1] !== last_accept) $display("[TB] FAIL two_words_we_latency: got cycle %0d expected %0d", wr_cyc[1], last_accept); else passes++;
    end
    checks++; if (done_cnt !== 1) $display("[TB] FAIL two_words_done_count: got %0d expected 1", done_cnt); else passes++;
    checks++; if (done_cyc !== last_accept + 1) $display("[TB] FAIL two_words_done_latency: got cycle %0d expected %0d", done_cyc, last_accept + 1); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL two_words_busy_after: got %b expected 0", busy); else passes++;
    checks++; if (ready_in_write !== 1'b0) $display("[TB] FAIL two_words_ready_in_write: got %b expected 0", ready_in_write); else passes++;
    checks++; if (timeout_seen !== 1'b0) $display("[TB] FAIL two_words_timeout: got %b expected 0", timeout_seen); else passes++;
  endtask

  task automatic test_toggle_valid();
    logic [31:0] w;
    clear_log();
    w = 32'hDEADBEEF;
    start_load(7'd1);
    for (int i = 3; i >= 0; i--) begin
      send_byte(w[i*8 +: 8]);
      bus.byte_valid = 1'b0;
      bus.byte_data  = 8'hFF;
      tick();
    end
    idle(3);
    checks++; if (wr_addr.size() !== 1) $display("[TB] FAIL toggle_count: got %0d expected 1", wr_addr.size()); else passes++;
    if (wr_addr.size() == 1) begin
      checks++; if (wr_addr[0] !== 6'd0) $display("[TB] FAIL toggle_addr: got %h expected 0", wr_addr[0]); else passes++;
      checks++; if (wr_data[0] !== 32'hDEADBEEF) $display("[TB] FAIL toggle_data: got %h expected deadbeef", wr_data[0]); else passes++;
    end
    checks++; if (ready_in_write !== 1'b0) $display("[TB] FAIL toggle_ready_in_write: got %b expected 0", ready_in_write); else passes++;
    checks++; if (done_cnt !== 1) $display("[TB] FAIL toggle_done_count: got %0d expected 1", done_cnt); else passes++;
    checks++; if (timeout_seen !== 1'b0) $display("[TB] FAIL toggle_timeout: got %b expected 0", timeout_seen); else passes++;
  endtask

  task automatic test_zero_len();
    clear_log();
    bus.byte_valid = 1'b1;
    bus.byte_data  = 8'h55;
    start_load(7'd0);
    checks++; if (done !== 1'b1) $display("[TB] FAIL zero_done: got %b expected 1", done); else passes++;
    checks++; if (bus.byte_ready !== 1'b0) $display("[TB] FAIL zero_byte_ready: got %b expected 0", bus.byte_ready); else passes++;
    tick();
    checks++; if (done !== 1'b0) $display("[TB] FAIL zero_done_pulse: got %b expected 0", done); else passes++;
    idle(3);
    bus.byte_valid = 1'b0;
    checks++; if (wr_addr.size() !== 0) $display("[TB] FAIL zero_writes: got %0d expected 0", wr_addr.size()); else passes++;
    checks++; if (busy_seen !== 1'b0) $display("[TB] FAIL zero_busy_seen: got %b expected 0", busy_seen); else passes++;
    checks++; if (done_cnt !== 1) $display("[TB] FAIL zero_done_count: got %0d expected 1", done_cnt); else passes++;
  endtask

  task automatic test_clamp();
    int bad;
    bit ready_after;
    clear_log();
    start_load(7'd127);
    for (int i = 0; i < 64; i++) send_word(32'h11111111);
    idle(2);
    ready_after = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (bus.byte_ready === 1'b1) ready_after = 1'b1;
    end
    bus.byte_valid = 1'b0;
    checks++; if (wr_addr.size() !== 64) $display("[TB] FAIL clamp_count: got %0d expected 64", wr_addr.size()); else passes++;
    bad = 0;
    for (int i = 0; i < wr_addr.size() && i < 64; i++)
      if (wr_addr[i] !== 6'(i) || wr_data[i] !== 32'h11111111) bad++;
    checks++; if (bad !== 0) $display("[TB] FAIL clamp_sequence: got %0d bad writes expected 0", bad); else passes++;
    if (wr_addr.size() == 64) begin
      checks++; if (wr_addr[63] !== 6'd63) $display("[TB] FAIL clamp_last_addr: got %h expected 3f", wr_addr[63]); else passes++;
      checks++; if (done_cyc !== wr_cyc[63] + 1) $display("[TB] FAIL clamp_done_latency: got cycle %0d expected %0d", done_cyc, wr_cyc[63] + 1); else passes++;
    end
    checks++; if (done_cnt !== 1) $display("[TB] FAIL clamp_done_count: got %0d expected 1", done_cnt); else passes++;
    checks++; if (ready_after !== 1'b0) $display("[TB] FAIL clamp_ready_after: got %b expected 0", ready_after); else passes++;
    checks++; if (timeout_seen !== 1'b0) $display("[TB] FAIL clamp_timeout: got %b expected 0", timeout_seen); else passes++;
  endtask

  task automatic test_reset_mid_load();
    clear_log();
    start_load(7'd3);
    send_word(32'h01020304);
    send_byte(8'hAA);
    send_byte(8'hBB);
    bus.byte_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (bus.byte_ready !== 1'b0) $display("[TB] FAIL abort_byte_ready: got %b expected 0", bus.byte_ready); else passes++;
    checks++; if (bus.we !== 1'b0) $display("[TB] FAIL abort_we: got %b expected 0", bus.we); else passes++;
    checks++; if (bus.waddr !== '0) $display("[TB] FAIL abort_waddr: got %h expected 0", bus.waddr); else passes++;
    checks++; if (bus.wdata !== '0) $display("[TB] FAIL abort_wdata: got %h expected 0", bus.wdata); else passes++;
    checks++; if (busy !== 1'b0) $display("[TB] FAIL abort_busy: got %b expected 0", busy); else passes++;
    checks++; if (done !== 1'b0) $display("[TB] FAIL abort_done: got %b expected 0", done); else passes++;
    idle(3);
    checks++; if (wr_addr.size() !== 1) $display("[TB] FAIL abort_write_count: got %0d expected 1", wr_addr.size()); else passes++;
    if (wr_addr.size() >= 1) begin
      checks++; if (wr_data[0] !== 32'h01020304) $display("[TB] FAIL abort_word0: got %h expected 01020304", wr_data[0]); else passes++;
    end
    checks++; if (done_cnt !== 0) $display("[TB] FAIL abort_no_done: got %0d expected 0", done_cnt); else passes++;
    start_load(7'd1);
    send_word(32'h0000000C);
    bus.byte_valid = 1'b0;
    idle(3);
    checks++; if (wr_addr.size() !== 2) $display("[TB] FAIL reload_count: got %0d expected 2", wr_addr.size()); else passes++;
    if (wr_addr.size() == 2) begin
      checks++; if (wr_addr[1] !== 6'd0) $display("[TB] FAIL reload_addr: got %h expected 0", wr_addr[1]); else passes++;
      checks++; if (wr_data[1] !== 32'h0000000C) $display("[TB] FAIL reload_data: got %h expected 0000000c", wr_data[1]); else passes++;
    end
    checks++; if (done_cnt !== 1) $display("[TB] FAIL reload_done_count: got %0d expected 1", done_cnt); else passes++;
    checks++; if (timeout_seen !== 1'b0) $display("[TB] FAIL abort_timeout: got %b expected 0", timeout_seen); else passes++;
  endtask

  task automatic test_start_mid_load();
    clear_log();
    start_load(7'd2);
    send_byte(8'h20);
    start    = 1'b1;
    load_len = 7'd1;
    send_byte(8'h08);
    send_byte(8'h00);
    send_byte(8'h05);
    send_byte(8'hAC);
    send_byte(8'h08);
    start = 1'b0;
    send_byte(8'h00);
    send_byte(8'h40);
    bus.byte_valid = 1'b0;
    idle(3);
    checks++; if (wr_addr.size() !== 2) $display("[TB] FAIL restart_count: got %0d expected 2", wr_addr.size()); else passes++;
    if (wr_addr.size() == 2) begin
      checks++; if (wr_addr[0] !== 6'd0 || wr_data[0] !== 32'h20080005) $display("[TB] FAIL restart_word0: got %h@%h expected 20080005@00", wr_data[0], wr_addr[0]); else passes++;
      checks++; if (wr_addr[1] !== 6'd1 || wr_data[1] !== 32'hAC080040) $display("[TB] FAIL restart_word1: got %h@%h expected ac080040@01", wr_data[1], wr_addr[1]); else passes++;
    end
    checks++; if (done_cnt !== 1) $display("[TB] FAIL restart_done_count: got %0d expected 1", done_cnt); else passes++;
    checks++; if (timeout_seen !== 1'b0) $display("[TB] FAIL restart_timeout: got %b expected 0", timeout_seen); else passes++;
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset          = 1'b1;
    start          = 1'b0;
    load_len       = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;
    clear_log();
    test_reset();
    test_two_words();
    test_toggle_valid();
    test_zero_len();
    test_clamp();
    test_reset_mid_load();
    test_start_mid_load();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
